// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch front end sitting between the core's PC logic and inst_rom. It drives
// the ROM address, captures the combinational ROM data in the same cycle and
// buffers {pc, inst} pairs in a small prefetch FIFO. Decode drains the FIFO
// over a valid/ready handshake. Branch redirects from execute flush the buffer
// and restart fetch at the target.
//
// Parameters:
//   DEPTH    - prefetch FIFO entries (power of two, >= 2)
//   ADDR_W   - address width (matches ADDR_BUS)
//   INST_W   - instruction width (matches INST_BUS)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   rst              in   synchronous active-low reset
//   rom_en           out  ROM read enable (high only when a fetch happens)
//   rom_addr         out  ROM byte address (fetch pc), 0 when not fetching
//   rom_inst         in   ROM data, valid in the same cycle as rom_addr
//   br_valid         in   redirect request from execute
//   br_target        in   redirect address
//   halt             in   pause new fetches; the buffer keeps draining
//   if_excp_misalign out  one-cycle pulse after a misaligned redirect
//                         (only present with IFU_ALIGN_CHECK_EN)
//   id_valid         out  FIFO head entry available
//   id_ready         in   decode accepts the head entry
//   id_pc            out  pc of the head entry (0 when empty)
//   id_inst          out  instruction of the head entry (0 when empty)
//
// Build option:
//   IFU_ALIGN_CHECK_EN - when defined, a redirect to a target whose low two
//   bits are non-zero raises if_excp_misalign for one cycle, flushes the FIFO
//   and parks the FSM in FAULT (no fetch, no valid) until reset. When not
//   defined, the low two target bits are cleared before loading the pc.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
`ifdef IFU_ALIGN_CHECK_EN
    output logic              if_excp_misalign,
`endif
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_WAKE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef IFU_ALIGN_CHECK_EN
    localparam logic [1:0] S_FAULT = 2'd3;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

`ifdef IFU_ALIGN_CHECK_EN
    logic              r_excp;
`endif

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic              w_full;
    logic              w_empty;
    logic              w_fetch;
    logic              w_pop;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_br_pc;
    logic [1:0]        w_state_nxt;
`ifdef IFU_ALIGN_CHECK_EN
    logic              w_misalign;
`endif

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

`ifdef IFU_ALIGN_CHECK_EN
    // FAULT is terminal until reset, so redirects there are ignored as well.
    assign w_redirect = br_valid && (r_state != S_WAKE) && (r_state != S_FAULT);
    assign w_misalign = (br_target[1:0] != 2'b00);
    assign w_br_pc    = br_target;
`else
    assign w_redirect = br_valid && (r_state != S_WAKE);
    // Low two bits are dropped: the pc is always word aligned.
    assign w_br_pc    = br_target & ~ADDR_W'(3);
`endif

    // Fetch is gated on the current count only (not on a same-cycle pop) so
    // that id_ready never reaches rom_en combinationally.
    assign w_fetch = (r_state == S_RUN) && !halt && !w_full && !br_valid;

    assign w_pop   = id_valid && id_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAKE: w_state_nxt = S_RUN;
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!halt) begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_FAULT: w_state_nxt = S_FAULT;
`endif
            default: w_state_nxt = S_WAKE;
        endcase
`ifdef IFU_ALIGN_CHECK_EN
        if (w_redirect && w_misalign) begin
            w_state_nxt = S_FAULT;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Control registers: FSM, pc, pointers, count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_WAKE;
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                // Redirect wins over any same-cycle pop; the buffer is emptied.
                r_pc     <= w_br_pc;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_fetch) begin
                    r_pc     <= r_pc + ADDR_W'(4);
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_fetch, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (data path, no reset needed: id_* are gated by count)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && w_fetch) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_inst[r_wr_ptr] <= rom_inst;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    // -------------------------------------------------------------------------
    // Misalignment exception pulse: one cycle, since FAULT blocks redirects.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_excp <= 1'b0;
        end else begin
            r_excp <= w_redirect && w_misalign;
        end
    end

    assign if_excp_misalign = r_excp;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_en   = w_fetch;
    assign rom_addr = w_fetch ? r_pc : '0;

    assign id_valid = !w_empty;
    assign id_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign id_inst  = w_empty ? '0 : r_mem_inst[r_rd_ptr];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Self-checking bench for inst_fetch_unit. ROM word[i] = i. Every observed
// fetch pushes the bench's own expected {pc, inst} onto a queue; every decode
// handshake pops and compares. Redirects and resets flush the queue and move
// the bench's pc model. Directed checks cover latency, full-buffer stall,
// halt/drain, redirect timing, reset mid-run and the misaligned target.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        br_valid;
    logic [31:0] br_target;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef IFU_ALIGN_CHECK_EN
    logic        if_excp_misalign;
`endif

    int          checks;
    int          failures;
    logic [63:0] sb [$];
    logic [31:0] model_pc;
    bit          wake;

    inst_fetch_unit #(
        .DEPTH    (4),
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rom_en           (rom_en),
        .rom_addr         (rom_addr),
        .rom_inst         (rom_inst),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .halt             (halt),
`ifdef IFU_ALIGN_CHECK_EN
        .if_excp_misalign (if_excp_misalign),
`endif
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_pc            (id_pc),
        .id_inst          (id_inst)
    );

    // Combinational ROM: word[i] = i
    assign rom_inst = {2'b00, rom_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // Observe one cycle at the falling edge and update the scoreboard with what
    // the coming rising edge must do.
    task automatic sample();
        logic [63:0] e;
        bit          redir;
        @(negedge clk);
        if (rst) begin
            redir = br_valid && !wake;
            chk_eq("id_valid", id_valid, sb.size() != 0);
            if (!id_valid) begin
                chk_eq("id_pc_empty", id_pc, 0);
                chk_eq("id_inst_empty", id_inst, 0);
            end
            if (!rom_en) chk_eq("rom_addr_idle", rom_addr, 0);
            if (wake || halt || redir || sb.size() == 4)
                chk_eq("rom_en_blocked", rom_en, 0);
            if (id_valid && id_ready && !redir && sb.size() != 0) begin
                e = sb.pop_front();
                chk_eq("id_pc", id_pc, e[63:32]);
                chk_eq("id_inst", id_inst, e[31:0]);
            end
            if (rom_en) begin
                chk_eq("rom_addr", rom_addr, model_pc);
                sb.push_back({model_pc, 2'b00, model_pc[31:2]});
                model_pc = model_pc + 32'd4;
            end
            if (redir) begin
                sb.delete();
`ifdef IFU_ALIGN_CHECK_EN
                model_pc = br_target;
`else
                model_pc = {br_target[31:2], 2'b00};
`endif
            end
        end else begin
            sb.delete();
            model_pc = 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        wake = !rst;
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_pc  = 32'h0;
        wake      = 1'b1;
        rst       = 1'b0;
        halt      = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'h0;
        id_ready  = 1'b1;

        // ---- Reset release, streaming with id_ready=1 ----
        step();
        step();
        rst = 1'b1;
        sample(); chk_eq("t1_wake_en", rom_en, 0); chk_eq("t1_wake_valid", id_valid, 0); tick();
        sample(); chk_eq("t1_first_en", rom_en, 1); chk_eq("t1_first_addr", rom_addr, 32'h0); tick();
        sample(); chk_eq("t1_c3_pc", id_pc, 32'h0); chk_eq("t1_c3_inst", id_inst, 32'd0); tick();
        sample(); chk_eq("t1_c4_pc", id_pc, 32'h4); chk_eq("t1_c4_inst", id_inst, 32'd1); tick();
        repeat (8) begin
            sample(); chk_eq("t1_stream_en", rom_en, 1); chk_eq("t1_stream_valid", id_valid, 1); tick();
        end

        // ---- id_ready=0 from reset release: fill to DEPTH, then drain ----
        rst = 1'b0; step();
        rst = 1'b1; id_ready = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            sample(); chk_eq("t2_fill_en", rom_en, 1); chk_eq("t2_fill_addr", rom_addr, 32'(4 * i)); tick();
        end
        repeat (3) begin
            sample(); chk_eq("t2_full_en", rom_en, 0); chk_eq("t2_full_head", id_pc, 32'h0); tick();
        end
        id_ready = 1'b1;
        sample(); chk_eq("t2_full_pop_en", rom_en, 0); tick();
        sample(); chk_eq("t2_restart_addr", rom_addr, 32'h10); tick();
        repeat (4) step();

        // ---- Redirect with 3 entries buffered ----
        rst = 1'b0; step();
        rst = 1'b1; id_ready = 1'b0; step();
        repeat (3) step();
        id_ready = 1'b1; br_valid = 1'b1; br_target = 32'h100;
        sample(); chk_eq("t3_redir_en", rom_en, 0); chk_eq("t3_redir_valid", id_valid, 1); tick();
        br_valid = 1'b0;
        sample(); chk_eq("t3_after_valid", id_valid, 0); chk_eq("t3_target_addr", rom_addr, 32'h100); tick();
        sample(); chk_eq("t3_target_pc", id_pc, 32'h100); chk_eq("t3_target_inst", id_inst, 32'h40); tick();
        repeat (3) step();

        // ---- Halt for 5 cycles during streaming ----
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk_eq("t4_halt_en", rom_en, 0);
            if (i > 0) chk_eq("t4_drained", id_valid, 0);
            tick();
        end
        halt = 1'b0;
        sample(); chk_eq("t4_hold_exit", rom_en, 0); tick();
        sample(); chk_eq("t4_resume_en", rom_en, 1); tick();
        repeat (3) step();

        // ---- Redirect while in HOLD ----
        halt = 1'b1;
        step();
        step();
        br_valid = 1'b1; br_target = 32'h200;
        sample(); chk_eq("t4b_hold_redir_en", rom_en, 0); tick();
        br_valid = 1'b0;
        step();
        halt = 1'b0;
        step();
        sample(); chk_eq("t4b_target_addr", rom_addr, 32'h200); tick();
        repeat (2) step();

        // ---- Reset while full; redirect during WAKE is ignored ----
        id_ready = 1'b0;
        repeat (6) step();
        rst = 1'b0; step();
        rst = 1'b1; br_valid = 1'b1; br_target = 32'h300;
        sample(); chk_eq("t5_valid", id_valid, 0); chk_eq("t5_wake_en", rom_en, 0); tick();
        br_valid = 1'b0; id_ready = 1'b1;
        sample(); chk_eq("t5_restart_en", rom_en, 1); chk_eq("t5_restart_addr", rom_addr, 32'h0); tick();
        repeat (3) step();

        // ---- Misaligned redirect target ----
        br_valid = 1'b1; br_target = 32'h102;
        step();
        br_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        sample();
        chk_eq("t6_excp_pulse", if_excp_misalign, 1);
        chk_eq("t6_fault_en", rom_en, 0);
        chk_eq("t6_fault_valid", id_valid, 0);
        tick();
        repeat (4) begin
            sample();
            chk_eq("t6_excp_clear", if_excp_misalign, 0);
            chk_eq("t6_fault_en", rom_en, 0);
            chk_eq("t6_fault_valid", id_valid, 0);
            tick();
        end
`else
        sample(); chk_eq("t6_aligned_en", rom_en, 1); chk_eq("t6_aligned_addr", rom_addr, 32'h100); tick();
        sample(); chk_eq("t6_aligned_pc", id_pc, 32'h100); tick();
        repeat (2) step();
`endif
        rst = 1'b0; step();
        rst = 1'b1; step();
        sample(); chk_eq("t7_recover_addr", rom_addr, 32'h0); chk_eq("t7_recover_en", rom_en, 1); tick();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
